// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display blocks.
// Segment vectors are active-low, ordered ABCDEFG with segment A in bit SEG_A_BIT.
package seg7_pkg;

    localparam int unsigned SEG_A_BIT = 6;
    localparam int unsigned NIB_W     = 4;

    localparam logic [SEG_A_BIT:0] SEG_0     = 7'b0000001;
    localparam logic [SEG_A_BIT:0] SEG_1     = 7'b1001111;
    localparam logic [SEG_A_BIT:0] SEG_2     = 7'b0010010;
    localparam logic [SEG_A_BIT:0] SEG_3     = 7'b0000110;
    localparam logic [SEG_A_BIT:0] SEG_4     = 7'b1001100;
    localparam logic [SEG_A_BIT:0] SEG_5     = 7'b0100100;
    localparam logic [SEG_A_BIT:0] SEG_6     = 7'b0100000;
    localparam logic [SEG_A_BIT:0] SEG_7     = 7'b0001111;
    localparam logic [SEG_A_BIT:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_A_BIT:0] SEG_9     = 7'b0000100;
    localparam logic [SEG_A_BIT:0] SEG_A     = 7'b0001000;
    localparam logic [SEG_A_BIT:0] SEG_B     = 7'b1100000;
    localparam logic [SEG_A_BIT:0] SEG_C     = 7'b0110001;
    localparam logic [SEG_A_BIT:0] SEG_D     = 7'b1000010;
    localparam logic [SEG_A_BIT:0] SEG_E     = 7'b0110000;
    localparam logic [SEG_A_BIT:0] SEG_F     = 7'b0111000;
    localparam logic [SEG_A_BIT:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-low 7-segment decoder.
// Ports:
//   nibble - 4-bit digit code
//   seg_c  - active-low segments ABCDEFG (A = MSB); codes 10..15 show
//            A,b,C,d,E,F when HEX_MODE != 0, otherwise blank
module seg7_hex_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned HEX_MODE = 0
) (
    input  logic [NIB_W-1:0]   nibble,
    output logic [SEG_A_BIT:0] seg_c
);

    localparam bit SHOW_HEX = (HEX_MODE != 0);

    // Digit lookup; letters collapse to blank outside hex mode
    always_comb begin
        seg_c = SEG_BLANK;
        case (nibble)
            4'h0: seg_c = SEG_0;
            4'h1: seg_c = SEG_1;
            4'h2: seg_c = SEG_2;
            4'h3: seg_c = SEG_3;
            4'h4: seg_c = SEG_4;
            4'h5: seg_c = SEG_5;
            4'h6: seg_c = SEG_6;
            4'h7: seg_c = SEG_7;
            4'h8: seg_c = SEG_8;
            4'h9: seg_c = SEG_9;
            4'hA: seg_c = SHOW_HEX ? SEG_A : SEG_BLANK;
            4'hB: seg_c = SHOW_HEX ? SEG_B : SEG_BLANK;
            4'hC: seg_c = SHOW_HEX ? SEG_C : SEG_BLANK;
            4'hD: seg_c = SHOW_HEX ? SEG_D : SEG_BLANK;
            4'hE: seg_c = SHOW_HEX ? SEG_E : SEG_BLANK;
            4'hF: seg_c = SHOW_HEX ? SEG_F : SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with a
// double-buffered value, per-digit decimal points, leading-zero blanking
// and a frame-done pulse.
// Ports:
//   clk, reset  - single clock, synchronous active-high reset
//   value_in    - nibble i drives digit i (digit 0 rightmost)
//   dp_in       - decimal point request per digit (1 = lit)
//   load        - strobe capturing value_in/dp_in into the pending buffer
//   blank_lz    - leading-zero blanking enable, used live
//   seg, dp     - active-low shared segment / decimal point lines
//   an          - active-low one-cold anode enables
//   frame_done  - one-cycle pulse after each completed scan
module seg7_mux_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned HEX_MODE    = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NIB_W*NUM_DIGITS-1:0]   value_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          load,
    input  logic                          blank_lz,
    output logic [SEG_A_BIT:0]            seg,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          frame_done
);

    localparam int unsigned VAL_W = NIB_W * NUM_DIGITS;
    localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]      prescaler;
    logic [IDX_W-1:0]      idx;
    logic [VAL_W-1:0]      pend_val;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic                  pend_valid;
    logic [VAL_W-1:0]      act_val;
    logic [NUM_DIGITS-1:0] act_dp;

    logic                  tick;
    logic                  wrap;
    logic [IDX_W-1:0]      idx_nxt;
    logic [VAL_W-1:0]      act_val_nxt;
    logic [NUM_DIGITS-1:0] act_dp_nxt;
    logic [NIB_W-1:0]      sel_nib;
    logic                  sel_dp;
    logic                  sel_blank;
    logic                  upper_zero;
    logic [SEG_A_BIT:0]    dec_seg;

    // Scan timing and active-buffer swap; a load on the wrap cycle bypasses pending
    always_comb begin
        tick        = (prescaler == PRE_LAST);
        wrap        = tick && (idx == IDX_LAST);
        idx_nxt     = idx;
        act_val_nxt = act_val;
        act_dp_nxt  = act_dp;
        if (wrap) begin
            idx_nxt = '0;
        end else if (tick) begin
            idx_nxt = idx + IDX_W'(1);
        end
        if (wrap) begin
            if (load) begin
                act_val_nxt = value_in;
                act_dp_nxt  = dp_in;
            end else if (pend_valid) begin
                act_val_nxt = pend_val;
                act_dp_nxt  = pend_dp;
            end
        end
    end

    // Select the digit being shown next; walk from the top digit down so
    // upper_zero says whether this nibble and all above it are zero
    always_comb begin
        sel_nib    = '0;
        sel_dp     = 1'b0;
        sel_blank  = 1'b0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (act_val_nxt[NIB_W*i +: NIB_W] == '0);
            if (idx_nxt == IDX_W'(i)) begin
                sel_nib   = act_val_nxt[NIB_W*i +: NIB_W];
                sel_dp    = act_dp_nxt[i];
                sel_blank = blank_lz && upper_zero && (i != 0);
            end
        end
    end

    seg7_hex_decoder #(
        .HEX_MODE (HEX_MODE)
    ) u_dec (
        .nibble (sel_nib),
        .seg_c  (dec_seg)
    );

    // State and registered display outputs; outputs only move on tick edges
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler  <= '0;
            idx        <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            act_val    <= '0;
            act_dp     <= '0;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            prescaler  <= tick ? '0 : prescaler + PRE_W'(1);
            idx        <= idx_nxt;
            act_val    <= act_val_nxt;
            act_dp     <= act_dp_nxt;
            frame_done <= wrap;
            if (load && !wrap) begin
                pend_val   <= value_in;
                pend_dp    <= dp_in;
                pend_valid <= 1'b1;
            end else if (wrap) begin
                pend_valid <= 1'b0;
            end
            if (tick) begin
                an  <= ~(NUM_DIGITS'(1) << idx_nxt);
                seg <= sel_blank ? SEG_BLANK : dec_seg;
                dp  <= ~sel_dp;
            end
        end
    end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Scoreboard bench for seg7_mux_driver (4 digits, 4-cycle slots), running a
// hex-mode and a decimal-mode instance side by side on the same inputs.
module tb_seg7_mux_driver;

    localparam int unsigned ND = 4;
    localparam int unsigned RD = 4;

    // Hand-written segment codes (active-low ABCDEFG)
    localparam logic [6:0] S0  = 7'b0000001;
    localparam logic [6:0] S1  = 7'b1001111;
    localparam logic [6:0] S2  = 7'b0010010;
    localparam logic [6:0] S3  = 7'b0000110;
    localparam logic [6:0] S4  = 7'b1001100;
    localparam logic [6:0] S5  = 7'b0100100;
    localparam logic [6:0] S6  = 7'b0100000;
    localparam logic [6:0] S7  = 7'b0001111;
    localparam logic [6:0] S8  = 7'b0000000;
    localparam logic [6:0] S9  = 7'b0000100;
    localparam logic [6:0] SA  = 7'b0001000;
    localparam logic [6:0] SHB = 7'b1100000;
    localparam logic [6:0] SC  = 7'b0110001;
    localparam logic [6:0] SF  = 7'b0111000;
    localparam logic [6:0] BL  = 7'b1111111;

    typedef struct packed {
        logic [31:0] slot;
        logic [3:0]  an;
        logic [6:0]  sh;
        logic [6:0]  sd;
        logic        dp;
        logic        fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;

    logic [6:0]  seg_h, seg_d;
    logic        dp_h, dp_d, fd_h, fd_d;
    logic [3:0]  an_h, an_d;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    seg7_mux_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .HEX_MODE(1)) dut_hex (
        .clk(clk), .reset(reset), .value_in(value_in), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .seg(seg_h), .dp(dp_h), .an(an_h), .frame_done(fd_h)
    );

    seg7_mux_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .HEX_MODE(0)) dut_dec (
        .clk(clk), .reset(reset), .value_in(value_in), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .seg(seg_d), .dp(dp_d), .an(an_d), .frame_done(fd_d)
    );

    // Edges since reset release; output edges are the multiples of RD
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_slot(input int slot, input int idx, input logic [6:0] sh,
                             input logic [6:0] sd, input logic dpbit);
        exp_t e;
        e.slot = 32'(slot);
        e.an   = ~(4'b0001 << idx);
        e.sh   = sh;
        e.sd   = sd;
        e.dp   = ~dpbit;
        e.fd   = (idx == 0);
        q.push_back(e);
    endtask

    // Digits packed {d3,d2,d1,d0}; n slots starting at the wrap slot m
    task automatic push_frame(input int m, input logic [27:0] sh, input logic [27:0] sd,
                              input logic [3:0] dpm, input int n);
        for (int i = 0; i < n; i++)
            push_slot(m + i, i, sh[7*i +: 7], sd[7*i +: 7], dpm[i]);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input int c, input logic [15:0] v, input logic [3:0] d);
        goto(c);
        value_in = v;
        dp_in    = d;
        load     = 1'b1;
        goto(c + 1);
        load     = 1'b0;
        value_in = 16'hEEEE;
        dp_in    = 4'hF;
    endtask

    // Monitor: reset values, scoreboard pops on output edges, idle frame_done
    always @(negedge clk) begin
        exp_t e;
        int   s;
        if (cyc == 0) begin
            chk("rst_an_h", 32'(an_h), 32'hF);
            chk("rst_an_d", 32'(an_d), 32'hF);
            chk("rst_seg_h", 32'(seg_h), 32'h7F);
            chk("rst_seg_d", 32'(seg_d), 32'h7F);
            chk("rst_dp_h", 32'(dp_h), 32'h1);
            chk("rst_dp_d", 32'(dp_d), 32'h1);
            chk("rst_fd_h", 32'(fd_h), 32'h0);
            chk("rst_fd_d", 32'(fd_d), 32'h0);
        end else if (cyc % RD == 0) begin
            s = cyc / RD;
            while (q.size() > 0 && q[0].slot < 32'(s)) begin
                total++;
                bad++;
                $display("FAIL missed_slot: slot %0d not checked, now at slot %0d", q[0].slot, s);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].slot == 32'(s)) begin
                e = q.pop_front();
                chk($sformatf("slot%0d_an_h", s), 32'(an_h), 32'(e.an));
                chk($sformatf("slot%0d_an_d", s), 32'(an_d), 32'(e.an));
                chk($sformatf("slot%0d_seg_h", s), 32'(seg_h), 32'(e.sh));
                chk($sformatf("slot%0d_seg_d", s), 32'(seg_d), 32'(e.sd));
                chk($sformatf("slot%0d_dp_h", s), 32'(dp_h), 32'(e.dp));
                chk($sformatf("slot%0d_dp_d", s), 32'(dp_d), 32'(e.dp));
                chk($sformatf("slot%0d_fd_h", s), 32'(fd_h), 32'(e.fd));
                chk($sformatf("slot%0d_fd_d", s), 32'(fd_d), 32'(e.fd));
            end
        end else begin
            chk("idle_fd_h", 32'(fd_h), 32'h0);
            chk("idle_fd_d", 32'(fd_d), 32'h0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete at cyc %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Power-up: digits 1..3 then repeating frames of zeros
        for (int i = 1; i < 4; i++) push_slot(i, i, S0, S0, 1'b0);
        push_frame(4,  {S0, S0, S0, S0}, {S0, S0, S0, S0}, 4'b0000, 4);
        push_frame(8,  {S0, S0, S0, S0}, {S0, S0, S0, S0}, 4'b0000, 4);
        // 1234 loaded mid-frame 8, visible from wrap 12
        push_frame(12, {S1, S2, S3, S4}, {S1, S2, S3, S4}, 4'b0000, 4);
        // ABCF: letters in hex mode, blank in decimal mode
        push_frame(16, {SA, SHB, SC, SF}, {BL, BL, BL, BL}, 4'b0000, 4);
        // Leading-zero blanking
        push_frame(20, {BL, BL, S5, S0}, {BL, BL, S5, S0}, 4'b0000, 4);
        push_frame(24, {BL, BL, BL, S0}, {BL, BL, BL, S0}, 4'b0000, 4);
        // Decimal point on a blanked digit
        push_frame(28, {BL, BL, BL, S5}, {BL, BL, BL, S5}, 4'b0100, 4);
        // Load on the wrap cycle goes straight to the new frame
        push_frame(32, {S9, S8, S7, S6}, {S9, S8, S7, S6}, 4'b0001, 4);
        // Two loads in one frame: last wins; reset lands before slot 39
        push_frame(36, {BL, BL, S4, S2}, {BL, BL, S4, S2}, 4'b0000, 3);
        reset = 1'b0;

        do_load(38, 16'h1234, 4'b0000);
        do_load(54, 16'hABCF, 4'b0000);
        goto(70);
        blank_lz = 1'b1;
        do_load(70, 16'h0050, 4'b0000);
        do_load(86, 16'h0000, 4'b0000);
        do_load(102, 16'h0005, 4'b0100);
        do_load(127, 16'h9876, 4'b0001);
        do_load(130, 16'h1111, 4'b1111);
        do_load(134, 16'h0042, 4'b0000);
        do_load(150, 16'h3333, 4'b1111);

        // Reset mid-frame with 3333 pending: it must never appear
        goto(153);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        for (int i = 1; i < 4; i++) push_slot(i, i, BL, BL, 1'b0);
        push_frame(4, {BL, BL, BL, S0}, {BL, BL, BL, S0}, 4'b0000, 4);
        push_frame(8, {BL, BL, BL, S0}, {BL, BL, BL, S0}, 4'b0000, 4);
        reset = 1'b0;

        goto(46);
        while (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL leftover_slot: slot %0d expected but never reached", q[0].slot);
            void'(q.pop_front());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
